posit_encode_pipe: RTL and testbench

- Parametrised posit encoder for the accumulator output path.
- Takes sign, signed scale factor, wide fraction and status flags. Produces a WIDTH-bit posit with EXP exponent bits.
- Selectable rounding (RNE / truncate) and overflow policy (saturate / NaR).
- 3-stage valid/ready pipeline with full backpressure; replaces the fixed vld_d-sequenced encoder.

---
 rtl/posit_encode_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_posit_encode_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/posit_encode_pipe.sv
// Three-stage posit encoder: decode scale factor into regime/exponent, assemble the
// shifted magnitude bitstring, then round, saturate and pack into a WIDTH-bit posit.
module posit_encode_pipe #(
  parameter int WIDTH  = 16,
  parameter int EXP    = 2,
  parameter int FRAC_W = 2*(WIDTH-3-EXP)+1,
  parameter int SF_W   = $clog2(WIDTH)+EXP+2
) (
  input  logic              clk_i,
  input  logic              rstn,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  input  logic              sign_i,
  input  logic [SF_W-1:0]   sf_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              nzero_i,
  input  logic              ovf_i,
  input  logic              udf_i,
  input  logic              nar_i,
  input  logic              rnd_mode_i,
  input  logic              ovf_mode_i,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [WIDTH-1:0]  posit_o,
  output logic              inexact_o
);

  localparam int WTMP  = WIDTH+EXP+FRAC_W+1;
  localparam int RUN_W = $clog2(WIDTH+1);
  localparam logic signed [SF_W-1:0] K_MAX = SF_W'(WIDTH-2);
  localparam logic signed [SF_W-1:0] K_MIN = -K_MAX;

  typedef enum logic [2:0] {
    CLS_NORM = 3'd0,
    CLS_NAR  = 3'd1,
    CLS_OVF  = 3'd2,
    CLS_UDF  = 3'd3,
    CLS_ZERO = 3'd4,
    CLS_MIN  = 3'd5
  } cls_t;

  // Handshake: a beat moves on when valid & ready are both high on a rising edge.
  // All stages advance together on en; en depends only on the output register and
  // out_rdy_i, so there is no combinational path from the input side to the output.
  logic en;
  assign en       = ~out_vld_o | out_rdy_i;
  assign in_rdy_o = en;

  // ---------------- S1: decode ----------------
  logic signed [SF_W-1:0] k_s;
  cls_t                   cls_d;
  logic [RUN_W-1:0]       run_d;

  always_comb begin
    k_s   = $signed(sf_i) >>> EXP;
    cls_d = CLS_NORM;
    run_d = '0;
    if (nar_i)              cls_d = CLS_NAR;
    else if (ovf_i)         cls_d = CLS_OVF;
    else if (udf_i)         cls_d = CLS_UDF;
    else if (!nzero_i)      cls_d = CLS_ZERO;
    else if (k_s > K_MAX)   cls_d = CLS_OVF;
    else if (k_s < K_MIN)   cls_d = CLS_MIN;
    // run length includes the terminating bit
    if (!k_s[SF_W-1]) run_d = RUN_W'(k_s + SF_W'(2));
    else              run_d = RUN_W'(SF_W'(1) - k_s);
  end

  logic              s1_vld;
  logic              s1_sign;
  cls_t              s1_cls;
  logic              s1_kneg;
  logic [RUN_W-1:0]  s1_run;
  logic [EXP-1:0]    s1_e;
  logic [FRAC_W-1:0] s1_frac;
  logic              s1_rnd;
  logic              s1_ovfm;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_cls  <= CLS_ZERO;
      s1_kneg <= 1'b0;
      s1_run  <= '0;
      s1_e    <= '0;
      s1_frac <= '0;
      s1_rnd  <= 1'b0;
      s1_ovfm <= 1'b0;
    end else if (en) begin
      s1_vld  <= in_vld_i;
      s1_sign <= sign_i;
      s1_cls  <= cls_d;
      s1_kneg <= k_s[SF_W-1];
      s1_run  <= run_d;
      s1_e    <= sf_i[EXP-1:0];
      s1_frac <= frac_i;
      s1_rnd  <= rnd_mode_i;
      s1_ovfm <= ovf_mode_i;
    end
  end

  // ---------------- S2: assemble ----------------
  // The terminating regime bit leads the word; shifting by run-1 places it at the
  // end of the run, and for k >= 0 the vacated top bits are filled with ones.
  logic [RUN_W-1:0] sh;
  logic [WTMP-1:0]  base;
  logic [WTMP-1:0]  fill;
  logic [WTMP-1:0]  bits_d;

  always_comb begin
    sh     = s1_run - RUN_W'(1);
    base   = {s1_kneg, s1_e, s1_frac, {WIDTH{1'b0}}};
    fill   = s1_kneg ? '0 : ~({WTMP{1'b1}} >> sh);
    bits_d = (base >> sh) | fill;
  end

  logic            s2_vld;
  logic            s2_sign;
  cls_t            s2_cls;
  logic [WTMP-1:0] s2_bits;
  logic            s2_rnd;
  logic            s2_ovfm;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_cls  <= CLS_ZERO;
      s2_bits <= '0;
      s2_rnd  <= 1'b0;
      s2_ovfm <= 1'b0;
    end else if (en) begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_bits <= bits_d;
      s2_rnd  <= s1_rnd;
      s2_ovfm <= s1_ovfm;
    end
  end

  // ---------------- S3: round and pack ----------------
  logic [WIDTH-2:0] kept;
  logic             guard;
  logic             sticky;
  logic             rnd_up;
  logic [WIDTH-2:0] mag;
  logic             neg;
  logic             is_nar;
  logic             ix_d;
  logic [WIDTH-1:0] word;

  always_comb begin
    kept   = s2_bits[WTMP-1 -: WIDTH-1];
    guard  = s2_bits[WTMP-WIDTH];
    sticky = |s2_bits[WTMP-WIDTH-1:0];
    // an all-ones magnitude is maxpos; rounding must not carry into the sign bit
    rnd_up = ~s2_rnd & guard & (kept[0] | sticky) & ~(&kept);
    mag    = kept + (WIDTH-1)'(rnd_up);
    neg    = s2_sign;
    is_nar = 1'b0;
    ix_d   = guard | sticky;
    case (s2_cls)
      CLS_NORM: ;
      CLS_NAR: begin
        is_nar = 1'b1;
        ix_d   = 1'b0;
      end
      CLS_OVF: begin
        is_nar = s2_ovfm;
        mag    = '1;
        ix_d   = 1'b1;
      end
      CLS_MIN: begin
        mag  = (WIDTH-1)'(1);
        ix_d = 1'b1;
      end
      CLS_UDF: begin
        mag  = '0;
        neg  = 1'b0;
        ix_d = 1'b1;
      end
      default: begin
        mag  = '0;
        neg  = 1'b0;
        ix_d = 1'b0;
      end
    endcase
    word = {1'b0, mag};
    if (neg)    word = -word;
    if (is_nar) word = {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      out_vld_o <= 1'b0;
      posit_o   <= '0;
      inexact_o <= 1'b0;
    end else if (en) begin
      out_vld_o <= s2_vld;
      posit_o   <= word;
      inexact_o <= ix_d;
    end
  end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Directed bench for posit_encode_pipe at WIDTH=8, EXP=2: exact encodings, rounding,
// saturation classes, backpressure ordering/stability and mid-stream reset.
module tb_posit_encode_pipe;

  logic       clk_i = 1'b0;
  logic       rstn;
  logic       in_vld_i;
  logic       in_rdy_o;
  logic       sign_i;
  logic [6:0] sf_i;
  logic [6:0] frac_i;
  logic       nzero_i;
  logic       ovf_i;
  logic       udf_i;
  logic       nar_i;
  logic       rnd_mode_i;
  logic       ovf_mode_i;
  logic       out_vld_o;
  logic       out_rdy_i;
  logic [7:0] posit_o;
  logic       inexact_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_tab [10] = '{8'h40, 8'h48, 8'h50, 8'h58, 8'h60,
                               8'h64, 8'h68, 8'h6C, 8'h70, 8'h72};

  posit_encode_pipe #(.WIDTH(8), .EXP(2), .FRAC_W(7), .SF_W(7)) dut (
    .clk_i      (clk_i),
    .rstn       (rstn),
    .in_vld_i   (in_vld_i),
    .in_rdy_o   (in_rdy_o),
    .sign_i     (sign_i),
    .sf_i       (sf_i),
    .frac_i     (frac_i),
    .nzero_i    (nzero_i),
    .ovf_i      (ovf_i),
    .udf_i      (udf_i),
    .nar_i      (nar_i),
    .rnd_mode_i (rnd_mode_i),
    .ovf_mode_i (ovf_mode_i),
    .out_vld_o  (out_vld_o),
    .out_rdy_i  (out_rdy_i),
    .posit_o    (posit_o),
    .inexact_o  (inexact_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one isolated beat with out_rdy_i held high; checks latency, posit and inexact
  task automatic send_one(input string tag, input logic s, input int sf,
                          input logic [6:0] fr, input logic nz, input logic ov,
                          input logic ud, input logic na, input logic rm,
                          input logic om, input logic [7:0] ep, input logic ei);
    int lat;
    @(negedge clk_i);
    sign_i = s; sf_i = 7'(sf); frac_i = fr; nzero_i = nz; ovf_i = ov;
    udf_i = ud; nar_i = na; rnd_mode_i = rm; ovf_mode_i = om;
    in_vld_i = 1'b1;
    @(posedge clk_i);
    lat = 1;
    @(negedge clk_i);
    in_vld_i = 1'b0;
    while (!out_vld_o && lat < 10) begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end
    chk({tag, "_lat"}, lat, 3);
    chk(tag, int'(posit_o), int'(ep));
    chk({tag, "_ix"}, int'(inexact_o), int'(ei));
  endtask

  initial begin
    int sent, got, cyc;
    logic hold;
    logic [7:0] held;

    // reset
    rstn = 1'b1; in_vld_i = 1'b0; out_rdy_i = 1'b1; sign_i = 1'b0; sf_i = '0;
    frac_i = '0; nzero_i = 1'b1; ovf_i = 1'b0; udf_i = 1'b0; nar_i = 1'b0;
    rnd_mode_i = 1'b0; ovf_mode_i = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_vld", int'(out_vld_o), 0);
    chk("rst_posit", int'(posit_o), 0);
    chk("rst_ix", int'(inexact_o), 0);
    chk("rst_rdy", int'(in_rdy_o), 1);
    @(negedge clk_i);
    @(negedge clk_i);
    rstn = 1'b1;

    // exact encodings
    send_one("one",      0,  0, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h40, 0);
    send_one("neg_one",  1,  0, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'hC0, 0);
    send_one("sf1",      0,  1, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h48, 0);
    send_one("sf4",      0,  4, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h60, 0);
    send_one("sf_m1",    0, -1, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h38, 0);
    send_one("sf_m1_f",  0, -1, 7'b1000000, 1, 0, 0, 0, 0, 0, 8'h3C, 0);
    send_one("neg_sf1",  1,  1, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'hB8, 0);
    send_one("sf_m24",   0, -24, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h01, 0);

    // rounding
    send_one("tie_even", 0,  0, 7'b0001000, 1, 0, 0, 0, 0, 0, 8'h40, 1);
    send_one("tie_odd",  0,  0, 7'b0011000, 1, 0, 0, 0, 0, 0, 8'h42, 1);
    send_one("trunc",    0,  0, 7'b0011000, 1, 0, 0, 0, 1, 0, 8'h41, 1);
    send_one("max_rne",  0, 24, 7'b1111111, 1, 0, 0, 0, 0, 0, 8'h7F, 1);
    send_one("up_to_max",0, 23, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h7F, 1);

    // classes
    send_one("sat_p",    0, 30, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h7F, 1);
    send_one("sat_p_nar",0, 30, 7'b0000000, 1, 0, 0, 0, 0, 1, 8'h80, 1);
    send_one("sat_n",    1, 30, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h81, 1);
    send_one("sat_n_nar",1, 30, 7'b0000000, 1, 0, 0, 0, 0, 1, 8'h80, 1);
    send_one("ovf_flag", 0,  0, 7'b0000000, 1, 1, 0, 0, 0, 0, 8'h7F, 1);
    send_one("min_p",    0, -40, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h01, 1);
    send_one("min_n",    1, -40, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'hFF, 1);
    send_one("min_m25",  0, -25, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h01, 1);
    send_one("nar",      0,  0, 7'b0000000, 1, 1, 0, 1, 0, 0, 8'h80, 0);
    send_one("zero",     1,  5, 7'b0000000, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    send_one("udf",      1,  5, 7'b0000000, 1, 0, 1, 0, 0, 0, 8'h00, 1);

    // backpressure stream
    sent = 0; got = 0; cyc = 0; hold = 1'b0; held = '0;
    sign_i = 1'b0; frac_i = '0; nzero_i = 1'b1; ovf_i = 1'b0; udf_i = 1'b0;
    nar_i = 1'b0; rnd_mode_i = 1'b0; ovf_mode_i = 1'b0;
    while (got < 10 && cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      if (hold) begin
        chk("bp_hold_vld", int'(out_vld_o), 1);
        chk("bp_hold_data", int'(posit_o), int'(held));
      end
      out_rdy_i = 1'($urandom_range(0, 1));
      if (cyc >= 4 && cyc <= 6) out_rdy_i = 1'b0;
      in_vld_i = (sent < 10);
      sf_i = 7'(sent);
      #1;
      chk("bp_rdy", int'(in_rdy_o), int'(!(out_vld_o && !out_rdy_i)));
      if (out_vld_o && out_rdy_i) begin
        chk("bp_q_nonempty", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("bp_data", int'(posit_o), int'(exp_q.pop_front()));
        got++;
      end
      if (in_vld_i && in_rdy_o) begin
        exp_q.push_back(exp_tab[sent]);
        sent++;
      end
      hold = out_vld_o && !out_rdy_i;
      held = posit_o;
    end
    chk("bp_count", got, 10);
    chk("bp_q_empty", exp_q.size(), 0);
    @(negedge clk_i);
    in_vld_i = 1'b0; out_rdy_i = 1'b1;

    // reset with three beats in flight
    @(negedge clk_i);
    sf_i = 7'(0); in_vld_i = 1'b1;
    @(negedge clk_i);
    sf_i = 7'(1);
    @(negedge clk_i);
    sf_i = 7'(2);
    @(negedge clk_i);
    in_vld_i = 1'b0;
    chk("rst_mid_pre_vld", int'(out_vld_o), 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_vld", int'(out_vld_o), 0);
    chk("rst_mid_posit", int'(posit_o), 0);
    chk("rst_mid_rdy", int'(in_rdy_o), 1);
    @(negedge clk_i);
    chk("rst_mid_vld_next", int'(out_vld_o), 0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("rst_flush_vld", int'(out_vld_o), 0);
    end
    send_one("after_rst", 0, 4, 7'b0000000, 1, 0, 0, 0, 0, 0, 8'h60, 0);
    @(negedge clk_i);
    chk("after_rst_alone", int'(out_vld_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
